// File: rtl/cpu_fsm.sv
// cpu_fsm: top-level control sequencer of the micro-coded CPU.
// Steps each instruction through fixed macro states. Each state lasts a fixed
// number of micro-steps. The micro-instruction address is decoded into
// datapath control strobes.
//
// Ports:
//   sys_clk        system clock; every state update happens on the rising edge
//   sys_reset      synchronous, active-low reset
//   is_nop         current instruction is a NOP; only looked at in DECODE
//   cpu_state      current macro state (registered)
//   fsm_assist     micro-step index within the current state (registered)
//   current_minst  micro-instruction address (registered)
//   mem_en         memory access strobe
//   ir_load        instruction-register load strobe
//   alu_en         ALU execute strobe
//   reg_we         register-file write enable
//   pc_inc         program-counter increment strobe
//   instr_done     one-cycle pulse at instruction retirement
module cpu_fsm #(
  parameter int unsigned CPU_STATES = 8,
  parameter int unsigned MINST_W    = 4,
  parameter int unsigned ASSIST_W   = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  input  logic                          is_nop,
  output logic [$clog2(CPU_STATES)-1:0] cpu_state,
  output logic [ASSIST_W-1:0]           fsm_assist,
  output logic [MINST_W-1:0]            current_minst,
  output logic                          mem_en,
  output logic                          ir_load,
  output logic                          alu_en,
  output logic                          reg_we,
  output logic                          pc_inc,
  output logic                          instr_done
);

  localparam int unsigned STATE_W = $clog2(CPU_STATES);

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_EXEC   = STATE_W'(3),
    S_MEM    = STATE_W'(4),
    S_WB     = STATE_W'(5),
    S_NEXT   = STATE_W'(6)
  } state_e;

  // State kept as raw bits so the unused encoding can exist and be recovered.
  logic [STATE_W-1:0]  state;
  logic [ASSIST_W-1:0] assist;
  logic [MINST_W-1:0]  minst;

  state_e              cur_state;
  state_e              next_state;
  logic [ASSIST_W-1:0] next_assist;
  logic [MINST_W-1:0]  next_minst;
  logic                illegal;

  // Index of the final micro-step of each state (dwell - 1).
  function automatic logic [ASSIST_W-1:0] last_step(input state_e s);
    logic [ASSIST_W-1:0] r;
    case (s)
      S_FETCH, S_EXEC, S_MEM: r = ASSIST_W'(1);
      default:                r = ASSIST_W'(0);
    endcase
    return r;
  endfunction

  // First micro-ROM address belonging to each state.
  function automatic logic [MINST_W-1:0] minst_base(input state_e s);
    logic [MINST_W-1:0] r;
    case (s)
      S_RESET:  r = MINST_W'(0);
      S_FETCH:  r = MINST_W'(1);
      S_DECODE: r = MINST_W'(3);
      S_EXEC:   r = MINST_W'(4);
      S_MEM:    r = MINST_W'(6);
      S_WB:     r = MINST_W'(8);
      S_NEXT:   r = MINST_W'(9);
      default:  r = MINST_W'(0);
    endcase
    return r;
  endfunction

  // Next-state, next micro-step and next micro-address.
  always_comb begin
    next_state  = S_FETCH;
    next_assist = '0;
    cur_state   = state_e'(state);
    illegal     = (state > STATE_W'(S_NEXT));

    if (illegal) begin
      next_state  = S_FETCH;
      next_assist = '0;
    end else if (assist != last_step(cur_state)) begin
      next_state  = cur_state;
      next_assist = assist + ASSIST_W'(1);
    end else begin
      next_assist = '0;
      case (cur_state)
        S_RESET:  next_state = S_FETCH;
        S_FETCH:  next_state = S_DECODE;
        S_DECODE: next_state = is_nop ? S_NEXT : S_EXEC;
        S_EXEC:   next_state = S_MEM;
        S_MEM:    next_state = S_WB;
        S_WB:     next_state = S_NEXT;
        S_NEXT:   next_state = S_FETCH;
        default:  next_state = S_FETCH;
      endcase
    end

    // Address is registered with the state so the three outputs always agree.
    next_minst = minst_base(next_state) + MINST_W'(next_assist);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      state  <= STATE_W'(S_RESET);
      assist <= '0;
      minst  <= '0;
    end else begin
      state  <= next_state;
      assist <= next_assist;
      minst  <= next_minst;
    end
  end

  // Micro-ROM: control strobes for each micro-address.
  always_comb begin
    mem_en     = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    pc_inc     = 1'b0;
    instr_done = 1'b0;
    case (minst)
      MINST_W'(1): mem_en = 1'b1;
      MINST_W'(2): begin
        mem_en  = 1'b1;
        ir_load = 1'b1;
      end
      MINST_W'(4), MINST_W'(5): alu_en = 1'b1;
      MINST_W'(6), MINST_W'(7): mem_en = 1'b1;
      MINST_W'(8): reg_we = 1'b1;
      MINST_W'(9): begin
        pc_inc     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_state     = state;
  assign fsm_assist    = assist;
  assign current_minst = minst;

endmodule

// File: tb/tb_cpu_fsm.sv
// tb_cpu_fsm: randomized self-checking bench for cpu_fsm against a
// table-driven model of the macro-state sequence.
module tb_cpu_fsm;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       is_nop;
  logic [2:0] cpu_state;
  logic [1:0] fsm_assist;
  logic [3:0] current_minst;
  logic       mem_en, ir_load, alu_en, reg_we, pc_inc, instr_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: macro state index and micro-step within it.
  int m_state = 0;
  int m_step  = 0;
  int dwell [7] = '{1, 2, 1, 2, 2, 1, 1};
  int base  [7] = '{0, 1, 3, 4, 6, 8, 9};

  int cyc       = 0;
  int last_done = -1;

  always #5 sys_clk = ~sys_clk;

  cpu_fsm dut (
    .sys_clk       (sys_clk),
    .sys_reset     (sys_reset),
    .is_nop        (is_nop),
    .cpu_state     (cpu_state),
    .fsm_assist    (fsm_assist),
    .current_minst (current_minst),
    .mem_en        (mem_en),
    .ir_load       (ir_load),
    .alu_en        (alu_en),
    .reg_we        (reg_we),
    .pc_inc        (pc_inc),
    .instr_done    (instr_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_minst();
    return (m_state > 6) ? 0 : base[m_state] + m_step;
  endfunction

  // {mem_en, ir_load, alu_en, reg_we, pc_inc, instr_done} per phase of an instruction.
  function automatic int exp_strobes();
    case (m_state)
      1:       return (m_step == 0) ? 'b100000 : 'b110000;
      3:       return 'b001000;
      4:       return 'b100000;
      5:       return 'b000100;
      6:       return 'b000011;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic nop);
    if (!rst) begin
      m_state = 0;
      m_step  = 0;
    end else if (m_state > 6) begin
      m_state = 1;
      m_step  = 0;
    end else if (m_step < dwell[m_state] - 1) begin
      m_step++;
    end else begin
      m_step = 0;
      case (m_state)
        0: m_state = 1;
        1: m_state = 2;
        2: m_state = nop ? 6 : 3;
        3: m_state = 4;
        4: m_state = 5;
        5: m_state = 6;
        default: m_state = 1;
      endcase
    end
  endtask

  task automatic compare_all();
    check("state",   int'(cpu_state),     m_state);
    check("assist",  int'(fsm_assist),    m_step);
    check("minst",   int'(current_minst), exp_minst());
    check("strobes", int'({mem_en, ir_load, alu_en, reg_we, pc_inc, instr_done}), exp_strobes());
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, compare 1 ns later.
  task automatic tick(input logic rst, input logic nop);
    @(negedge sys_clk);
    sys_reset = rst;
    is_nop    = nop;
    @(posedge sys_clk);
    cyc++;
    model_edge(rst, nop);
    #1;
    compare_all();
  endtask

  // Checks spacing between retirement pulses against the expected period.
  task automatic check_gap(input int period);
    if (instr_done) begin
      if (last_done >= 0) check("done_gap", cyc - last_done, period);
      last_done = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t;
    bit   found;
    sys_reset = 1'b0;
    is_nop    = 1'b0;

    // Reset held for two edges.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Normal instructions: 9-cycle retirement period.
    last_done = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      check_gap(9);
    end

    // NOPs held: 4-cycle period, no execute/memory/writeback strobes.
    last_done = -1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b1);
      check_gap(4);
      check("nop_no_alu", int'(alu_en), 0);
      check("nop_no_we",  int'(reg_we), 0);
    end

    // is_nop toggling every cycle: only the DECODE value matters.
    t = 1'b0;
    for (int i = 0; i < 40; i++) begin
      t = ~t;
      tick(1'b1, t);
    end

    // Reset in the middle of MEM (minst 7).
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0);
      if (exp_minst() == 7) found = 1'b1;
    end
    check("reach_mem", int'(found), 1);
    tick(1'b0, 1'b0);
    check("mid_reset_minst", int'(current_minst), 0);
    tick(1'b1, 1'b0);
    check("restart_fetch", int'(cpu_state), 1);

    // Illegal state 7 recovers to FETCH on the next edge.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    @(negedge sys_clk);
    force dut.state = 3'd7;
    #1;
    check("forced_state", int'(cpu_state), 7);
    release dut.state;
    m_state = 7;
    @(posedge sys_clk);
    cyc++;
    model_edge(1'b1, is_nop);
    #1;
    compare_all();
    check("illegal_recover_minst", int'(current_minst), 1);

    // Random NOP flags with occasional resets.
    for (int i = 0; i < 250; i++) begin
      tick(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_fsm.md
Name: cpu_fsm

Overview:
- Top-level control sequencer of the micro-coded CPU.
- Steps each instruction through fixed macro states. Each state lasts a fixed number of micro-steps.
- Exposes the current macro state, the micro-step counter (fsm_assist) and the micro-instruction address (current_minst).
- Decodes current_minst into datapath control strobes. A NOP instruction skips execute, memory and writeback.

Parameters:
- CPU_STATES, 8, number of macro-state encodings; cpu_state width is $clog2(CPU_STATES) = 3.
- MINST_W, 4, width of current_minst.
- ASSIST_W, 2, width of fsm_assist.

Ports:
- sys_clk  input  1  single system clock; all state updates on rising edge.
- sys_reset  input  1  synchronous, active-low reset.
- is_nop  input  1  decoder flag: current instruction is a NOP; sampled only in DECODE.
- cpu_state  output  $clog2(CPU_STATES)  current macro state, registered.
- fsm_assist  output  ASSIST_W  micro-step index within the current state, registered.
- current_minst  output  MINST_W  micro-instruction address, registered.
- mem_en  output  1  memory access strobe.
- ir_load  output  1  instruction-register load strobe.
- alu_en  output  1  ALU execute strobe.
- reg_we  output  1  register-file write enable.
- pc_inc  output  1  program-counter increment strobe.
- instr_done  output  1  one-cycle pulse at instruction retirement.

Behaviour:
- Reset: sys_reset==0 at a rising edge sets cpu_state=0 (RESET), fsm_assist=0 and current_minst=0. Reset has priority over everything else, including mid-instruction. Control outputs are all 0 while current_minst=0.
- State encodings and dwell (cycles spent in the state):
  - RESET=0, dwell 1
  - FETCH=1, dwell 2
  - DECODE=2, dwell 1
  - EXEC=3, dwell 2
  - MEM=4, dwell 2
  - WB=5, dwell 1
  - NEXT=6, dwell 1
  - 7 is unused.
- fsm_assist:
  - Counts 0..dwell-1 while in a state.
  - At fsm_assist==dwell-1 the state advances and fsm_assist returns to 0.
  - Otherwise fsm_assist increments and the state holds.
- Transitions, taken on the last micro-step of each state:
  - RESET->FETCH
  - FETCH->DECODE
  - DECODE->NEXT if is_nop==1, else DECODE->EXEC
  - EXEC->MEM
  - MEM->WB
  - WB->NEXT
  - NEXT->FETCH
- Illegal state 7 goes to FETCH on the next edge with fsm_assist=0.
- current_minst = base(state) + fsm_assist, registered together with the state so it is always consistent with cpu_state/fsm_assist.
  - Bases: RESET 0, FETCH 1, DECODE 3, EXEC 4, MEM 6, WB 8, NEXT 9. Illegal state gives 0.
  - Valid range is 0..9; values 10..15 never occur.
- Micro-ROM decode, combinational from current_minst; all other strobes 0:
  - 1: mem_en
  - 2: mem_en, ir_load
  - 3: none
  - 4, 5: alu_en
  - 6, 7: mem_en
  - 8: reg_we
  - 9: pc_inc, instr_done
- Latency:
  - Non-NOP instruction takes 9 cycles, FETCH entry to the next FETCH entry.
  - NOP takes 4 cycles.
  - First FETCH appears 1 cycle after reset deasserts.
- is_nop is ignored in every state other than DECODE. Toggling it elsewhere has no effect.
- Steady state: the sequence repeats indefinitely. There is no halt state.

Test Plan:
- Hold sys_reset=0 for 2 edges -> cpu_state=0, fsm_assist=0, current_minst=0, all strobes 0.
- Release reset with is_nop=0, log 20 edges -> required (state, assist, minst) sequence:
  - (0,0,0)
  - (1,0,1), (1,1,2)
  - (2,0,3)
  - (3,0,4), (3,1,5)
  - (4,0,6), (4,1,7)
  - (5,0,8)
  - (6,0,9)
  - (1,0,1), …
  - instr_done pulses exactly once per 9 cycles.
- is_nop=1 held -> FETCH(2 cycles), DECODE, NEXT, FETCH…; minst sequence 1,2,3,9,1. alu_en, reg_we and the MEM-state mem_en never assert.
- Toggle is_nop every cycle except during DECODE -> only the value present in DECODE selects the path.
- Assert sys_reset=0 while in MEM (minst=7) -> next edge gives state 0 / minst 0. After release the sequence restarts at RESET then FETCH.
- Force cpu_state to 7 via the bench -> next edge gives cpu_state=1, fsm_assist=0, current_minst=1.
